jtframe_z80_romrq: RTL
======================

Name: jtframe_z80_romrq

Overview:
- Responder end of the Z80 ROM handshake. Takes the CPU-side `rom_cs`/address and returns `rom_ok` plus a data byte.
- Serves bytes from a small 32-bit line cache. On a miss it issues a word request to the SDRAM arbiter.
- Sits between the Z80 wait-state wrapper (which gates `cpu_cen` while `rom_cs & ~rom_ok`) and the SDRAM controller slot.

Parameters:
- AW, 15, byte address width of the CPU ROM region (min 3).
- SDW, 32, SDRAM word width; fixed at 32, 4 bytes per line.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- invalidate  in  1  clears all cache lines (ROM download/reload)
- rom_cs  in  1  CPU ROM access request
- rom_addr  in  AW  CPU byte address
- rom_ok  out  1  data valid for the current `rom_addr`
- rom_data  out  8  byte for `rom_addr`
- sdram_req  out  1  word request to arbiter, level-held until ack
- sdram_addr  out  AW-2  word address, `rom_addr[AW-1:2]`, latched at request
- sdram_ack  in  1  arbiter accepted the request
- sdram_dok  in  1  `sdram_data` valid, single-cycle pulse
- sdram_data  in  32  fetched word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all line valid bits cleared, state IDLE
  - `sdram_req`=0, `sdram_addr`=0, discard flag cleared
  - `rom_ok`=0, since no line is valid
- Hit: `hit = valid & (tag == rom_addr[AW-1:2])`.
  - `rom_ok = rom_cs & hit`, combinational from registered tag/valid.
  - Zero-cycle latency on a hit.
- `rom_data`: byte of the hit line selected by `rom_addr[1:0]`, little-endian (0 → bits 7:0, 3 → bits 31:24). Don't-care when `rom_ok`=0.
- FSM IDLE / REQ / WAIT:
  - IDLE: `rom_cs & ~hit & ~invalidate` → latch `sdram_addr`, set `sdram_req`=1, go to REQ.
  - REQ: hold `sdram_req`=1 until `sdram_ack`. On ack, drop req next edge and go to WAIT. If `sdram_dok` arrives in the same cycle as the ack, fill immediately and go to IDLE.
  - WAIT: on `sdram_dok`, write `sdram_data` to the victim line, set tag = latched `sdram_addr`, set valid (unless discard), go to IDLE.
- Earliest `rom_ok` after a fill is the cycle following the `dok` edge.
- A fetch in flight always completes. `rom_cs` deasserting or `rom_addr` changing does not abort it; the line is filled and the address is re-evaluated in IDLE.
- Invalidate:
  - In IDLE: clears valid bits.
  - In REQ/WAIT: clears valid bits and sets the discard flag. The pending fill does not set valid; the flag clears on that fill.
  - Same cycle as `dok`: the invalidate wins and the line stays invalid.
- `sdram_ack` or `sdram_dok` while IDLE is ignored, and so is `dok` while in REQ without `ack`.
- Reset mid-REQ/WAIT: `sdram_req` drops at that edge; a late `dok` after reset is ignored (FSM in IDLE).
- No back-to-back requests: at least one IDLE cycle separates fetches.

Optional Feature:
- Macro: JTFRAME_ROMRQ_2WAY_EN
- Defined: two lines, both compared in parallel.
  - A hit in line 1 takes priority if both match, which cannot happen in correct operation.
  - Victim is the least-recently-hit line, tracked by an LRU bit updated on every `rom_ok` cycle and on fill (filled line becomes MRU).
  - Invalidate clears both lines.
- Undefined: a single line; every miss replaces it; no LRU state.

Decomposition:
- Package `jtframe_romrq_pkg`:
  - FSM state enum (IDLE/REQ/WAIT)
  - LINE_BYTES=4 and byte-select width 2
  - `byte_sel` function (32→8 mux)
- Sub-module `jtframe_romrq_line`:
  - holds tag, data and valid for one line
  - inputs: fill strobe, clear strobe
  - outputs: hit and selected byte
  - instantiated once, or twice under JTFRAME_ROMRQ_2WAY_EN

Test Plan:
- Cold miss: reset, rom_cs=1, rom_addr=0x0010.
  - rom_ok=0 and sdram_req=1 with sdram_addr=0x004.
  - ack after 2 cycles, dok 3 cycles later with 0xDDCCBBAA.
  - rom_ok=1 the next cycle with rom_data=0xAA.
- Hits: rom_addr 0x0011/0x0012/0x0013 → rom_ok=1 the same cycle, rom_data 0xBB/0xCC/0xDD, sdram_req stays 0.
- New miss: rom_addr=0x0014 → sdram_req=1, sdram_addr=0x005. Returning to 0x0010:
  - 1-way build: refetch of 0x004.
  - 2-way build: immediate hit, 0xAA.
- Same-cycle handshake: sdram_ack and sdram_dok together in REQ with 0x11223344 at addr 0x0020 → FSM back in IDLE next edge, rom_ok=1, rom_data=0x44.
- Invalidate mid-WAIT: pulse invalidate, then dok with 0x55667788 → rom_ok stays 0, a new sdram_req is issued for the same word, and the second dok yields rom_ok=1.
- Reset mid-WAIT: rst_n=0 for 1 cycle → sdram_req=0 and rom_ok=0; a late dok is ignored, and a later access to the same address misses.

Source files
------------

// File: rtl/jtframe_romrq_pkg.sv
// Shared types and helpers for the Z80 ROM request cache (jtframe_z80_romrq).
package jtframe_romrq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int LINE_BYTES = 4;
    localparam int BSEL_W     = 2;

    // Little-endian byte pick: select 0 is bits 7:0, select 3 is bits 31:24
    function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                            input logic [BSEL_W-1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtframe_romrq_line.sv
// One cache line (tag, 32-bit data, valid) for jtframe_z80_romrq.
// Instantiated twice when JTFRAME_ROMRQ_2WAY_EN is defined.
module jtframe_romrq_line
    import jtframe_romrq_pkg::*;
#(
    parameter int TW = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              fill_i,
    input  logic              fill_valid_i,
    input  logic [TW-1:0]     fill_tag_i,
    input  logic [31:0]       fill_data_i,
    input  logic [TW-1:0]     look_tag_i,
    input  logic [BSEL_W-1:0] look_sel_i,
    output logic              hit_o,
    output logic [7:0]        byte_o
);

    logic          valid_q;
    logic [TW-1:0] tag_q;
    logic [31:0]   data_q;

    // A clear in the same cycle as a fill leaves the line invalid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= fill_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q  <= fill_tag_i;
            data_q <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == look_tag_i);
    assign byte_o = byte_sel(data_q, look_sel_i);

endmodule

// File: rtl/jtframe_z80_romrq.sv
// Z80 ROM responder with a 32-bit line cache and SDRAM word fetch on miss.
// Define JTFRAME_ROMRQ_2WAY_EN for two LRU-replaced lines instead of one.
module jtframe_z80_romrq
    import jtframe_romrq_pkg::*;
#(
    parameter int AW  = 15,
    parameter int SDW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            invalidate,
    input  logic            rom_cs,
    input  logic [AW-1:0]   rom_addr,
    output logic            rom_ok,
    output logic [7:0]      rom_data,
    output logic            sdram_req,
    output logic [AW-3:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_dok,
    input  logic [SDW-1:0]  sdram_data
);

    localparam int TW = AW - 2;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [TW-1:0] addr_q, addr_d;
    logic          discard_q, discard_d;

    logic [TW-1:0]     look_tag;
    logic [BSEL_W-1:0] look_sel;
    logic              fill;
    logic              fill_valid;
    logic              hit;
    logic [7:0]        line_byte;

    assign look_tag = rom_addr[AW-1:2];
    assign look_sel = rom_addr[1:0];

    assign fill = ((state_q == REQ) && sdram_ack && sdram_dok) ||
                  ((state_q == WAIT) && sdram_dok);
    assign fill_valid = ~discard_q & ~invalidate;

`ifdef JTFRAME_ROMRQ_2WAY_EN
    logic       hit0, hit1;
    logic [7:0] byte0, byte1;
    logic       lru_q, lru_d;

    jtframe_romrq_line #(.TW(TW)) u_line0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (invalidate),
        .fill_i       (fill & ~lru_q),
        .fill_valid_i (fill_valid),
        .fill_tag_i   (addr_q),
        .fill_data_i  (sdram_data),
        .look_tag_i   (look_tag),
        .look_sel_i   (look_sel),
        .hit_o        (hit0),
        .byte_o       (byte0)
    );

    jtframe_romrq_line #(.TW(TW)) u_line1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (invalidate),
        .fill_i       (fill & lru_q),
        .fill_valid_i (fill_valid),
        .fill_tag_i   (addr_q),
        .fill_data_i  (sdram_data),
        .look_tag_i   (look_tag),
        .look_sel_i   (look_sel),
        .hit_o        (hit1),
        .byte_o       (byte1)
    );

    assign hit       = hit0 | hit1;
    assign line_byte = hit1 ? byte1 : byte0;

    // lru_q names the victim; a fill makes the filled line most recent
    always_comb begin
        lru_d = lru_q;
        if (fill) begin
            lru_d = ~lru_q;
        end else if (rom_cs && hit) begin
            lru_d = ~hit1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q <= 1'b0;
        end else begin
            lru_q <= lru_d;
        end
    end
`else
    jtframe_romrq_line #(.TW(TW)) u_line0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (invalidate),
        .fill_i       (fill),
        .fill_valid_i (fill_valid),
        .fill_tag_i   (addr_q),
        .fill_data_i  (sdram_data),
        .look_tag_i   (look_tag),
        .look_sel_i   (look_sel),
        .hit_o        (hit),
        .byte_o       (line_byte)
    );
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (rom_cs && !hit && !invalidate) begin
                    addr_d  = look_tag;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = sdram_dok ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (sdram_dok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        // An invalidate during a fetch poisons only that fetch's fill
        if (fill) begin
            discard_d = 1'b0;
        end else if (invalidate && (state_q != IDLE)) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    assign rom_ok     = rom_cs & hit;
    assign rom_data   = line_byte;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule
